bus_pckg_scoreboard: RTL and testbench

Synthesizable, parametrised scoreboard for the multi-driver bus environment. It takes every packet a driver launches (expected), routes it into a per-destination in-order queue keyed by the packet's ID field, and compares it against packets the monitors report at each destination port (observed). It counts matches, mismatches, unexpected arrivals, lost (timed-out) packets and overflows, and raises a sticky error. It replaces the software-only driver/monitor mailbox checker, adding per-channel ordering, a latency timeout and hardware counters.

---
 rtl/bus_pckg_scoreboard.sv | 175 +++++++++++++++++
 tb/tb_bus_pckg_scoreboard.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_pckg_scoreboard.sv
// Packet scoreboard: routes expected packets into per-destination FIFOs by ID and
// checks monitor-observed packets against the queue heads, with timeout and counters.
module bus_pckg_scoreboard #(
  parameter int DRVRS   = 4,
  parameter int PCKG_SZ = 16,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             exp_valid,
  input  logic [PCKG_SZ-1:0]               exp_pckg,
  input  logic [DRVRS-1:0]                 obs_valid,
  input  logic [DRVRS*PCKG_SZ-1:0]         obs_pckg,
  output logic [CNT_W-1:0]                 match_cnt,
  output logic [CNT_W-1:0]                 mism_cnt,
  output logic [CNT_W-1:0]                 unexp_cnt,
  output logic [CNT_W-1:0]                 miss_cnt,
  output logic [CNT_W-1:0]                 ovf_cnt,
  output logic                             err,
  output logic                             bad_id,
  output logic                             idle,
  output logic [$clog2(DRVRS*DEPTH+1)-1:0] pending
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int QCNT_W = $clog2(DEPTH + 1);
  localparam int AGE_W  = $clog2(TIMEOUT + 1);
  localparam int EV_W   = $clog2(DRVRS + 1);
  localparam int PEND_W = $clog2(DRVRS * DEPTH + 1);
  localparam int SUM_W  = CNT_W + EV_W;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_WAIT,
    ST_EXPIRE
  } ch_state_e;

  logic [PCKG_SZ-1:0] mem       [DRVRS][DEPTH];
  logic [PTR_W-1:0]   wr_ptr    [DRVRS];
  logic [PTR_W-1:0]   rd_ptr    [DRVRS];
  logic [QCNT_W-1:0]  q_cnt     [DRVRS];
  logic [QCNT_W-1:0]  q_cnt_nxt [DRVRS];
  logic [AGE_W-1:0]   age       [DRVRS];
  logic [AGE_W-1:0]   age_nxt   [DRVRS];
  ch_state_e          state     [DRVRS];

  logic [DRVRS-1:0] push;
  logic [DRVRS-1:0] pop;
  logic [EV_W-1:0]  n_match;
  logic [EV_W-1:0]  n_mism;
  logic [EV_W-1:0]  n_unexp;
  logic [EV_W-1:0]  n_miss;
  logic             ovf_ev;
  logic             bad_ev;
  logic [7:0]       exp_id;
  logic             id_ok;

  assign exp_id = exp_pckg[PCKG_SZ-1 -: 8];
  assign id_ok  = exp_id < 8'(DRVRS);
  assign bad_ev = exp_valid && !id_ok;

  // Saturating add of a per-cycle event count onto a counter.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [EV_W-1:0]  b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'({CNT_W{1'b1}})) return {CNT_W{1'b1}};
    return s[CNT_W-1:0];
  endfunction

  // Per-channel event decode. An observation always takes priority over an
  // expiring head, and a pop in the same cycle frees room for a push to a full queue.
  always_comb begin
    // NOTE: every comb output gets a default up front so no path infers a latch.
    push    = '0;
    pop     = '0;
    n_match = '0;
    n_mism  = '0;
    n_unexp = '0;
    n_miss  = '0;
    ovf_ev  = 1'b0;
    for (int i = 0; i < DRVRS; i++) begin
      q_cnt_nxt[i] = q_cnt[i];
      age_nxt[i]   = '0;
      if (obs_valid[i]) begin
        if (q_cnt[i] != '0) begin
          pop[i] = 1'b1;
          if (obs_pckg[i*PCKG_SZ +: PCKG_SZ] == mem[i][rd_ptr[i]])
            n_match = n_match + EV_W'(1);
          else
            n_mism = n_mism + EV_W'(1);
        end else begin
          n_unexp = n_unexp + EV_W'(1);
        end
      end else if (state[i] == ST_EXPIRE) begin
        pop[i] = 1'b1;
        n_miss = n_miss + EV_W'(1);
      end

      if (exp_valid && id_ok && (exp_id == 8'(i))) begin
        if ((q_cnt[i] == QCNT_W'(DEPTH)) && !pop[i]) ovf_ev = 1'b1;
        else push[i] = 1'b1;
      end

      case ({push[i], pop[i]})
        2'b10:   q_cnt_nxt[i] = q_cnt[i] + QCNT_W'(1);
        2'b01:   q_cnt_nxt[i] = q_cnt[i] - QCNT_W'(1);
        default: q_cnt_nxt[i] = q_cnt[i];
      endcase

      // Age restarts for each new head and stays at zero while the queue is empty.
      if (!pop[i] && (q_cnt[i] != '0)) age_nxt[i] = age[i] + AGE_W'(1);
    end
  end

  // NOTE: queue storage carries no reset; validity is tracked by the pointers and counts.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DRVRS; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= exp_pckg;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DRVRS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        q_cnt[i]  <= '0;
        age[i]    <= '0;
        state[i]  <= ST_EMPTY;
      end
      match_cnt <= '0;
      mism_cnt  <= '0;
      unexp_cnt <= '0;
      miss_cnt  <= '0;
      ovf_cnt   <= '0;
      err       <= 1'b0;
      bad_id    <= 1'b0;
    end else begin
      for (int i = 0; i < DRVRS; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        q_cnt[i] <= q_cnt_nxt[i];
        age[i]   <= age_nxt[i];
        if (q_cnt_nxt[i] == '0)
          state[i] <= ST_EMPTY;
        else if (age_nxt[i] == AGE_W'(TIMEOUT))
          state[i] <= ST_EXPIRE;
        else
          state[i] <= ST_WAIT;
      end
      match_cnt <= sat_add(match_cnt, n_match);
      mism_cnt  <= sat_add(mism_cnt, n_mism);
      unexp_cnt <= sat_add(unexp_cnt, n_unexp);
      miss_cnt  <= sat_add(miss_cnt, n_miss);
      ovf_cnt   <= sat_add(ovf_cnt, EV_W'(ovf_ev));
      if (bad_ev) bad_id <= 1'b1;
      if (bad_ev || ovf_ev || (n_mism != '0) || (n_unexp != '0) || (n_miss != '0))
        err <= 1'b1;
    end
  end

  always_comb begin
    pending = '0;
    idle    = 1'b1;
    for (int i = 0; i < DRVRS; i++) begin
      pending = pending + PEND_W'(q_cnt[i]);
      if (q_cnt[i] != '0) idle = 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_pckg_scoreboard.sv
// Directed bench for bus_pckg_scoreboard: ordering, mismatch, timeout, overflow,
// parallel events, saturation (second instance with CNT_W=2) and async reset.
module tb_bus_pckg_scoreboard;

  localparam int DRVRS   = 4;
  localparam int PCKG_SZ = 16;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 10;
  localparam int PEND_W  = $clog2(DRVRS * DEPTH + 1);

  logic                     clk;
  logic                     reset;
  logic                     exp_valid;
  logic [PCKG_SZ-1:0]       exp_pckg;
  logic [DRVRS-1:0]         obs_valid;
  logic [DRVRS*PCKG_SZ-1:0] obs_pckg;

  logic [15:0]       match_cnt, mism_cnt, unexp_cnt, miss_cnt, ovf_cnt;
  logic              err, bad_id, idle;
  logic [PEND_W-1:0] pending;

  logic [1:0]        s_match, s_mism, s_unexp, s_miss, s_ovf;
  logic              s_err, s_bad_id, s_idle;
  logic [PEND_W-1:0] s_pending;

  int n_checks = 0;
  int n_fail   = 0;

  bus_pckg_scoreboard #(
    .DRVRS(DRVRS), .PCKG_SZ(PCKG_SZ), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .exp_valid(exp_valid), .exp_pckg(exp_pckg),
    .obs_valid(obs_valid), .obs_pckg(obs_pckg),
    .match_cnt(match_cnt), .mism_cnt(mism_cnt), .unexp_cnt(unexp_cnt),
    .miss_cnt(miss_cnt), .ovf_cnt(ovf_cnt), .err(err), .bad_id(bad_id),
    .idle(idle), .pending(pending)
  );

  // Narrow-counter copy on the same stimulus, used for saturation checks.
  bus_pckg_scoreboard #(
    .DRVRS(DRVRS), .PCKG_SZ(PCKG_SZ), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(2)
  ) dut_sat (
    .clk(clk), .reset(reset), .exp_valid(exp_valid), .exp_pckg(exp_pckg),
    .obs_valid(obs_valid), .obs_pckg(obs_pckg),
    .match_cnt(s_match), .mism_cnt(s_mism), .unexp_cnt(s_unexp),
    .miss_cnt(s_miss), .ovf_cnt(s_ovf), .err(s_err), .bad_id(s_bad_id),
    .idle(s_idle), .pending(s_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] pkt);
    exp_valid = 1'b1;
    exp_pckg  = pkt;
    step();
    exp_valid = 1'b0;
  endtask

  task automatic obs(input int ch, input logic [15:0] pkt);
    obs_valid[ch]                  = 1'b1;
    obs_pckg[ch*PCKG_SZ +: PCKG_SZ] = pkt;
    step();
    obs_valid = '0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    exp_valid = 1'b0;
    exp_pckg  = '0;
    obs_valid = '0;
    obs_pckg  = '0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_match", 32'(match_cnt), 0);
    check("rst_err", 32'(err), 0);
    check("rst_bad_id", 32'(bad_id), 0);
    check("rst_idle", 32'(idle), 1);
    check("rst_pending", 32'(pending), 0);

    // Ordered traffic across three channels
    push(16'h00FF);
    push(16'h01AB);
    push(16'h02CC);
    push(16'h00DA);
    check("ord_pending", 32'(pending), 4);
    check("ord_idle0", 32'(idle), 0);
    obs(0, 16'h00FF);
    obs(1, 16'h01AB);
    obs(2, 16'h02CC);
    obs(0, 16'h00DA);
    check("ord_match", 32'(match_cnt), 4);
    check("ord_err", 32'(err), 0);
    check("ord_idle", 32'(idle), 1);
    check("ord_sat_match", 32'(s_match), 3);

    // Mismatch, unexpected, and push+obs in the same cycle into an empty queue
    push(16'h01AB);
    obs(1, 16'h01AC);
    check("mm_mism", 32'(mism_cnt), 1);
    check("mm_err", 32'(err), 1);
    obs(3, 16'h03AA);
    check("mm_unexp", 32'(unexp_cnt), 1);
    exp_valid = 1'b1;
    exp_pckg  = 16'h0377;
    obs(3, 16'h0377);
    exp_valid = 1'b0;
    check("same_cyc_unexp", 32'(unexp_cnt), 2);
    check("same_cyc_pending", 32'(pending), 1);
    obs(3, 16'h0377);
    check("same_cyc_match", 32'(match_cnt), 5);
    check("same_cyc_sat", 32'(s_match), 3);

    // Timeout: head visible after the push edge, miss on the edge ending cycle 10
    reset_dut();
    check("to_rst_err", 32'(err), 0);
    push(16'h02CC);
    check("to_pending1", 32'(pending), 1);
    repeat (TIMEOUT) step();
    check("to_not_yet", 32'(miss_cnt), 0);
    check("to_still_q", 32'(pending), 1);
    step();
    check("to_miss", 32'(miss_cnt), 1);
    check("to_pending0", 32'(pending), 0);
    check("to_err", 32'(err), 1);
    push(16'h02CC);
    repeat (TIMEOUT) step();
    obs(2, 16'h02CC);
    check("to_obs_wins_match", 32'(match_cnt), 1);
    check("to_obs_wins_miss", 32'(miss_cnt), 1);

    // Overflow, push+pop on a full queue, bad ID
    reset_dut();
    for (int k = 0; k < 9; k++) push(16'(k));
    check("ovf_cnt", 32'(ovf_cnt), 1);
    check("ovf_pending", 32'(pending), 8);
    exp_valid = 1'b1;
    exp_pckg  = 16'h00A0;
    obs(0, 16'h0000);
    exp_valid = 1'b0;
    check("ovf_pop_cnt", 32'(ovf_cnt), 1);
    check("ovf_pop_pending", 32'(pending), 8);
    check("ovf_pop_match", 32'(match_cnt), 1);
    check("bad_id_pre", 32'(bad_id), 0);
    push(16'h0512);
    check("bad_id_set", 32'(bad_id), 1);
    check("bad_id_pending", 32'(pending), 8);
    obs(0, 16'h0001);
    check("ovf_fifo_order", 32'(match_cnt), 2);

    // Parallel events on all four channels in one cycle
    reset_dut();
    push(16'h0011);
    push(16'h0122);
    push(16'h0233);
    push(16'h0344);
    obs_valid = 4'b1111;
    obs_pckg  = {16'h0300, 16'h02FF, 16'h0122, 16'h0011};
    step();
    obs_valid = '0;
    check("par_match", 32'(match_cnt), 2);
    check("par_mism", 32'(mism_cnt), 2);
    check("par_idle", 32'(idle), 1);
    check("par_sat_mism", 32'(s_mism), 2);
    for (int k = 0; k < 3; k++) begin
      push(16'h0060 + 16'(k));
      obs(0, 16'h0060 + 16'(k));
    end
    check("sat_main_match", 32'(match_cnt), 5);
    check("sat_match", 32'(s_match), 3);

    // Asynchronous reset between edges with traffic queued
    push(16'h0055);
    push(16'h0166);
    push(16'h0077);
    check("ar_pending3", 32'(pending), 3);
    #2;
    reset = 1'b1;
    #1;
    check("ar_pending", 32'(pending), 0);
    check("ar_idle", 32'(idle), 1);
    check("ar_match", 32'(match_cnt), 0);
    check("ar_err", 32'(err), 0);
    #1;
    reset = 1'b0;
    step();
    obs(0, 16'h0055);
    check("ar_unexp", 32'(unexp_cnt), 1);
    check("ar_match_post", 32'(match_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
